// File: rtl/trace_packer_pkg.sv
// Shared types and helpers for the trace push packer: stage state encoding
// and a three-way minimum used to size each push.
package trace_packer_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_e;

  function automatic int unsigned min3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

endpackage

// File: rtl/lane_compactor.sv
// Purely combinational lane compactor: packs the valid lanes of a beat into
// ascending slots using a per-lane prefix popcount.
module lane_compactor
  import trace_packer_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int NUM_LANES  = 4,
  parameter int CNT_W      = $clog2(NUM_LANES + 1)
) (
  input  logic [NUM_LANES-1:0]                 i_vld,
  input  logic [NUM_LANES-1:0][DATA_WIDTH-1:0] i_data,
  output logic [NUM_LANES-1:0][DATA_WIDTH-1:0] o_data,
  output logic [CNT_W-1:0]                     o_cnt
);

  logic [NUM_LANES-1:0][CNT_W-1:0] prefix;
  logic [CNT_W-1:0]                runCnt;

  // prefix[k] is the slot lane k lands in when it is valid
  always_comb begin
    runCnt = '0;
    prefix = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      prefix[k] = runCnt;
      runCnt    = runCnt + CNT_W'(i_vld[k]);
    end
  end

  assign o_cnt = runCnt;

  always_comb begin
    o_data = '0;
    for (int j = 0; j < NUM_LANES; j++) begin
      for (int k = 0; k < NUM_LANES; k++) begin
        if (i_vld[k] && (prefix[k] == CNT_W'(j))) begin
          o_data[j] = i_data[k];
        end
      end
    end
  end

endmodule

// File: rtl/trace_psh_packer.sv
// Compacts sparse trace beats and drains them into a multi-port FIFO without
// exceeding its free space. Optional macro TRACE_PACKER_DROP_EN drops stalled beats.
module trace_psh_packer
  import trace_packer_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int NUM_LANES  = 4,
  parameter int NUM_WR     = 2,
  parameter int ENTRIES    = 8,
  parameter int ADDR_SIZE  = (ENTRIES == 1) ? 1 : $clog2(ENTRIES),
  parameter int DROP_CNT_W = 8
) (
  input  logic                                 i_clk,
  input  logic                                 i_reset,
  input  logic [NUM_LANES-1:0]                 i_vld,
  input  logic [NUM_LANES-1:0][DATA_WIDTH-1:0] i_data,
  output logic                                 o_rdy,
  input  logic                                 i_flush,
  input  logic [ADDR_SIZE:0]                   i_fifo_cnt,
  output logic [NUM_WR-1:0]                    o_psh,
  output logic [NUM_WR-1:0][DATA_WIDTH-1:0]    o_data
`ifdef TRACE_PACKER_DROP_EN
  ,output logic [DROP_CNT_W-1:0]               o_drop_cnt
`endif
);

  localparam int CNT_W = $clog2(NUM_LANES + 1);
  localparam logic [ADDR_SIZE:0] DEPTH = (ADDR_SIZE + 1)'(ENTRIES);

  logic [NUM_LANES-1:0][DATA_WIDTH-1:0] stage_q, stage_d;
  logic [NUM_LANES-1:0][DATA_WIDTH-1:0] compData;
  logic [CNT_W-1:0]                     compCnt;
  logic [CNT_W-1:0]                     rem_q, rem_d;
  logic [CNT_W-1:0]                     hd_q, hd_d;
  state_e                               state_q, state_d;

  logic [ADDR_SIZE:0] freeSpace;
  logic [CNT_W-1:0]   pushN;
  logic [CNT_W-1:0]   remAfter;
  logic               beat;
  logic               canStage;
  logic               accept;

  lane_compactor #(
    .DATA_WIDTH(DATA_WIDTH),
    .NUM_LANES (NUM_LANES),
    .CNT_W     (CNT_W)
  ) u_compactor (
    .i_vld (i_vld),
    .i_data(i_data),
    .o_data(compData),
    .o_cnt (compCnt)
  );

  // An over-reported count is clamped so free space never wraps around
  always_comb begin
    freeSpace = '0;
    if (i_fifo_cnt <= DEPTH) begin
      freeSpace = DEPTH - i_fifo_cnt;
    end
  end

  always_comb begin
    pushN = '0;
    if (!i_reset && !i_flush && (state_q == DRAIN)) begin
      pushN = CNT_W'(min3(int'(rem_q), NUM_WR, int'(freeSpace)));
    end
    remAfter = rem_q - pushN;
    beat     = |i_vld;
    canStage = !i_reset && !i_flush && (remAfter == '0);
    accept   = beat && canStage;
  end

  // Port 0 always carries the oldest staged entry
  always_comb begin
    o_psh  = '0;
    o_data = '0;
    for (int i = 0; i < NUM_WR; i++) begin
      o_psh[i] = (i < int'(pushN));
      for (int j = 0; j < NUM_LANES; j++) begin
        if ((i < int'(pushN)) && (j == int'(hd_q) + i)) begin
          o_data[i] = stage_q[j];
        end
      end
    end
  end

`ifdef TRACE_PACKER_DROP_EN
  assign o_rdy = !i_reset;
`else
  assign o_rdy = canStage;
`endif

  always_comb begin
    stage_d = stage_q;
    hd_d    = hd_q + pushN;
    rem_d   = remAfter;
    state_d = (remAfter == '0) ? IDLE : DRAIN;
    if (i_reset || i_flush) begin
      hd_d    = '0;
      rem_d   = '0;
      state_d = IDLE;
    end else if (accept) begin
      stage_d = compData;
      hd_d    = '0;
      rem_d   = compCnt;
      state_d = DRAIN;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      hd_q    <= '0;
      rem_q   <= '0;
      state_q <= IDLE;
    end else begin
      hd_q    <= hd_d;
      rem_q   <= rem_d;
      state_q <= state_d;
    end
    stage_q <= stage_d;
  end

`ifdef TRACE_PACKER_DROP_EN
  logic [DROP_CNT_W-1:0] drop_q;
  logic                  dropBeat;

  // A beat that cannot be staged is discarded whole and counted once
  assign dropBeat   = beat && !i_reset && !canStage;
  assign o_drop_cnt = drop_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      drop_q <= '0;
    end else if (dropBeat && (drop_q != '1)) begin
      drop_q <= drop_q + 1'b1;
    end
  end
`else
  if (DROP_CNT_W < 1) begin : g_bad_drop_width
  end
`endif

endmodule

// File: tb/tb_trace_psh_packer.sv
// Self-checking bench for trace_psh_packer: directed scenarios plus random
// traffic against a queue-based model. Honours TRACE_PACKER_DROP_EN.
module tb_trace_psh_packer;

  localparam int DW      = 4;
  localparam int LANES   = 4;
  localparam int NWR     = 2;
  localparam int ENTRIES = 8;
  localparam int AS      = 3;
`ifdef TRACE_PACKER_DROP_EN
  localparam bit DropEn = 1'b1;
  localparam int DCW    = 2;
`else
  localparam bit DropEn = 1'b0;
  localparam int DCW    = 8;
`endif

  logic                        i_clk = 1'b0;
  logic                        i_reset;
  logic [LANES-1:0]            i_vld;
  logic [LANES-1:0][DW-1:0]    i_data;
  logic                        o_rdy;
  logic                        i_flush;
  logic [AS:0]                 i_fifo_cnt;
  logic [NWR-1:0]              o_psh;
  logic [NWR-1:0][DW-1:0]      o_data;
  logic [DCW-1:0]              dropObs;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] mq[$];
  int            expPn;
  bit            expCanStage;
  int            modelDrop = 0;

  trace_psh_packer #(
    .DATA_WIDTH(DW),
    .NUM_LANES (LANES),
    .NUM_WR    (NWR),
    .ENTRIES   (ENTRIES),
    .ADDR_SIZE (AS),
    .DROP_CNT_W(DCW)
  ) dut (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_vld     (i_vld),
    .i_data    (i_data),
    .o_rdy     (o_rdy),
    .i_flush   (i_flush),
    .i_fifo_cnt(i_fifo_cnt),
    .o_psh     (o_psh),
    .o_data    (o_data)
`ifdef TRACE_PACKER_DROP_EN
    ,.o_drop_cnt(dropObs)
`endif
  );

`ifndef TRACE_PACKER_DROP_EN
  assign dropObs = '0;
`endif

  always #5 i_clk = ~i_clk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [LANES-1:0] vld, input logic [LANES-1:0][DW-1:0] data,
                               input logic [AS:0] cnt, input logic flush, input logic rst);
    i_vld      = vld;
    i_data     = data;
    i_fifo_cnt = cnt;
    i_flush    = flush;
    i_reset    = rst;
    #2;
  endtask

  // Compare the whole cycle against the model at the falling edge, then advance the model
  task automatic checkOutput(input string tag);
    int sz, fr;
    logic [NWR-1:0]         eP;
    logic [NWR-1:0][DW-1:0] eD;
    @(negedge i_clk);
    sz = mq.size();
    fr = (int'(i_fifo_cnt) > ENTRIES) ? 0 : ENTRIES - int'(i_fifo_cnt);
    expPn = 0;
    if (!i_reset && !i_flush) begin
      expPn = sz;
      if (NWR < expPn) expPn = NWR;
      if (fr < expPn) expPn = fr;
    end
    expCanStage = !i_reset && !i_flush && (sz - expPn == 0);
    eP = '0;
    eD = '0;
    for (int i = 0; i < expPn; i++) begin
      eP[i] = 1'b1;
      eD[i] = mq[i];
    end
    checkVal({tag, ".psh"}, 32'(o_psh), 32'(eP));
    checkVal({tag, ".data"}, 32'(o_data), 32'(eD));
    checkVal({tag, ".rdy"}, 32'(o_rdy), DropEn ? 32'(!i_reset) : 32'(expCanStage));
    if (DropEn) checkVal({tag, ".drop"}, 32'(dropObs), 32'(modelDrop));
    @(posedge i_clk);
    if (i_reset) begin
      mq.delete();
      modelDrop = 0;
    end else begin
      if (i_flush) mq.delete();
      else for (int i = 0; i < expPn; i++) void'(mq.pop_front());
      if (|i_vld) begin
        if (expCanStage) begin
          for (int k = 0; k < LANES; k++) if (i_vld[k]) mq.push_back(i_data[k]);
        end else if (DropEn && modelDrop < (1 << DCW) - 1) begin
          modelDrop++;
        end
      end
    end
    #1;
  endtask

  initial begin
    applyStimulus('0, '0, '0, 1'b0, 1'b1);
    checkVal("reset.psh", 32'(o_psh), 0);
    checkVal("reset.rdy", 32'(o_rdy), 0);
    checkOutput("reset0");
    checkOutput("reset1");

    applyStimulus('0, '0, '0, 1'b0, 1'b0);
    checkVal("idle.rdy", 32'(o_rdy), 1);
    checkVal("idle.psh", 32'(o_psh), 0);
    checkOutput("idle");

    // Sparse beat
    applyStimulus(4'b1010, {4'hA, 4'h0, 4'h5, 4'h0}, '0, 1'b0, 1'b0);
    checkVal("sparse.rdyIn", 32'(o_rdy), 1);
    checkOutput("sparseLoad");
    applyStimulus('0, '0, '0, 1'b0, 1'b0);
    checkVal("sparse.psh", 32'(o_psh), 3);
    checkVal("sparse.d0", 32'(o_data[0]), 5);
    checkVal("sparse.d1", 32'(o_data[1]), 32'hA);
    checkVal("sparse.rdy", 32'(o_rdy), 1);
    checkOutput("sparseDrain");

    // Full beat, then a second beat held from cycle+1
    applyStimulus(4'b1111, {4'h4, 4'h3, 4'h2, 4'h1}, '0, 1'b0, 1'b0);
    checkOutput("fullLoad");
    applyStimulus(4'b1111, {4'h8, 4'h7, 4'h6, 4'h5}, '0, 1'b0, 1'b0);
    checkVal("full1.psh", 32'(o_psh), 3);
    checkVal("full1.d", 32'(o_data), 32'h21);
    checkVal("full1.rdy", 32'(o_rdy), DropEn ? 1 : 0);
    checkOutput("full1");
    checkVal("full2.d", 32'(o_data), 32'h43);
    checkVal("full2.rdy", 32'(o_rdy), 1);
    checkOutput("full2");
    applyStimulus('0, '0, '0, 1'b0, 1'b0);
    checkVal("full3.d", 32'(o_data), 32'h65);
    checkOutput("full3");
    checkVal("full4.d", 32'(o_data), 32'h87);
    checkOutput("full4");

    // Near-full FIFO
    applyStimulus(4'b0111, {4'h0, 4'hC, 4'hB, 4'hA}, 4'd7, 1'b0, 1'b0);
    checkOutput("nfLoad");
    applyStimulus('0, '0, 4'd7, 1'b0, 1'b0);
    checkVal("nf7.psh", 32'(o_psh), 1);
    checkVal("nf7.d0", 32'(o_data[0]), 32'hA);
    checkVal("nf7.rdy", 32'(o_rdy), DropEn ? 1 : 0);
    checkOutput("nf7");
    applyStimulus('0, '0, 4'd8, 1'b0, 1'b0);
    checkVal("nf8.psh", 32'(o_psh), 0);
    checkOutput("nf8");
    applyStimulus('0, '0, 4'd5, 1'b0, 1'b0);
    checkVal("nf5.psh", 32'(o_psh), 3);
    checkVal("nf5.d", 32'(o_data), 32'hCB);
    checkOutput("nf5");

    // Flush mid-drain
    applyStimulus(4'b1111, {4'h4, 4'h3, 4'h2, 4'h1}, '0, 1'b0, 1'b0);
    checkOutput("flLoad");
    applyStimulus('0, '0, '0, 1'b0, 1'b0);
    checkOutput("flDrain");
    applyStimulus('0, '0, '0, 1'b1, 1'b0);
    checkVal("flush.psh", 32'(o_psh), 0);
    checkVal("flush.rdy", 32'(o_rdy), DropEn ? 1 : 0);
    checkOutput("flush");
    applyStimulus('0, '0, '0, 1'b0, 1'b0);
    checkVal("postFlush.psh", 32'(o_psh), 0);
    checkVal("postFlush.rdy", 32'(o_rdy), 1);
    checkOutput("postFlush");

    // Reset mid-drain
    applyStimulus(4'b1111, {4'h4, 4'h3, 4'h2, 4'h1}, '0, 1'b0, 1'b0);
    checkOutput("rsLoad");
    applyStimulus('0, '0, '0, 1'b0, 1'b0);
    checkOutput("rsDrain");
    applyStimulus('0, '0, '0, 1'b0, 1'b1);
    checkVal("midReset.psh", 32'(o_psh), 0);
    checkVal("midReset.rdy", 32'(o_rdy), 0);
    checkOutput("midReset");
    applyStimulus('0, '0, '0, 1'b0, 1'b0);
    checkVal("postReset.psh", 32'(o_psh), 0);
    checkVal("postReset.rdy", 32'(o_rdy), 1);
    checkOutput("postReset");

`ifdef TRACE_PACKER_DROP_EN
    applyStimulus(4'b0011, {4'h0, 4'h0, 4'hE, 4'hD}, 4'd8, 1'b0, 1'b0);
    checkOutput("dropLoad");
    for (int b = 0; b < 5; b++) begin
      applyStimulus(4'b1111, {4'h1, 4'h2, 4'h3, 4'h4}, 4'd8, 1'b0, 1'b0);
      checkOutput("dropBeat");
      checkVal("dropCnt", 32'(dropObs), (b < 3) ? b + 1 : 3);
    end
    applyStimulus('0, '0, '0, 1'b0, 1'b0);
    checkVal("dropDrain.d", 32'(o_data), 32'hED);
    checkOutput("dropDrain");
`endif

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      applyStimulus(LANES'($urandom), (LANES * DW)'($urandom),
                    (AS + 1)'($urandom_range(0, 9)),
                    ($urandom_range(0, 19) == 0), ($urandom_range(0, 49) == 0));
      checkOutput("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
